// File: rtl/vote_session_ctrl_pkg.sv
// rtl/vote_session_ctrl_pkg.sv - shared types and constants for the ballot session controller
package vote_pkg;

  localparam int N_VOTERS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    TALLY  = 2'd2,
    RESULT = 2'd3
  } state_t;

  // 1-based verdict positions; the one-hot bit for each is at index V_x-1
  localparam int V_PASS = 1;
  localparam int V_TIE  = 2;
  localparam int V_FAIL = 3;

endpackage

// File: rtl/vote_session_ctrl_if.sv
// rtl/vote_session_ctrl_if.sv - voter/consumer handshake bundle for vote_session_ctrl
interface vote_session_ctrl_if;
  import vote_pkg::*;

  logic                start;
  logic                abort;
  logic                ack;
  logic [N_VOTERS-1:0] vote_valid;
  logic [N_VOTERS-1:0] vote_yes;
  logic                busy;
  logic [N_VOTERS-1:0] voted;
  logic [2:0]          yes_count;
  logic                result_valid;
  logic [2:0]          verdict;
  logic                timed_out;

  modport master (
    output start, abort, ack, vote_valid, vote_yes,
    input  busy, voted, yes_count, result_valid, verdict, timed_out
  );

  modport slave (
    input  start, abort, ack, vote_valid, vote_yes,
    output busy, voted, yes_count, result_valid, verdict, timed_out
  );

endinterface

// File: rtl/vote_session_ctrl_tally.sv
// rtl/vote_session_ctrl_tally.sv - combinational yes/no count and one-hot verdict
module vote_tally
  import vote_pkg::*;
(
  input  logic [N_VOTERS-1:0] voted,
  input  logic [N_VOTERS-1:0] yes,
  output logic [2:0]          yes_count,
  output logic [2:0]          verdict
);

  logic [2:0] n_yes;
  logic [2:0] n_no;

  // Non-voters abstain: only voted bits contribute to either side
  always_comb begin
    n_yes   = '0;
    n_no    = '0;
    verdict = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      if (voted[i]) begin
        if (yes[i]) n_yes = n_yes + 3'd1;
        else        n_no  = n_no + 3'd1;
      end
    end
    if (n_yes > n_no)       verdict[V_PASS-1] = 1'b1;
    else if (n_yes == n_no) verdict[V_TIE-1]  = 1'b1;
    else                    verdict[V_FAIL-1] = 1'b1;
    yes_count = n_yes;
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - timed four-voter ballot session with registered verdict
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  vote_session_ctrl_if.slave  bus
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [N_VOTERS-1:0] voted_r;
  logic [N_VOTERS-1:0] yes_r;
  logic [N_VOTERS-1:0] voted_nxt;
  logic [N_VOTERS-1:0] yes_nxt;
  logic                busy_r;
  logic                result_valid_r;
  logic                timed_out_r;
  logic [2:0]          yes_count_r;
  logic [2:0]          verdict_r;
  logic [2:0]          t_yes_count;
  logic [2:0]          t_verdict;

  // Only first strobes from voters who have not yet voted are taken
  assign voted_nxt = voted_r | bus.vote_valid;
  assign yes_nxt   = yes_r | (bus.vote_valid & ~voted_r & bus.vote_yes);

  vote_tally u_tally (
    .voted     (voted_r),
    .yes       (yes_r),
    .yes_count (t_yes_count),
    .verdict   (t_verdict)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      voted_r        <= '0;
      yes_r          <= '0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      timed_out_r    <= 1'b0;
      yes_count_r    <= '0;
      verdict_r      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= OPEN;
            busy_r      <= 1'b1;
            voted_r     <= '0;
            yes_r       <= '0;
            cnt         <= '0;
            timed_out_r <= 1'b0;
          end
        end
        OPEN: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            voted_r <= voted_nxt;
            yes_r   <= yes_nxt;
            cnt     <= cnt + CNT_W'(1);
            // A full ballot on the timeout cycle is not a timeout
            if (&voted_nxt) begin
              state <= TALLY;
            end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              state       <= TALLY;
              timed_out_r <= 1'b1;
            end
          end
        end
        TALLY: begin
          busy_r <= 1'b0;
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            state          <= RESULT;
            result_valid_r <= 1'b1;
            verdict_r      <= t_verdict;
            yes_count_r    <= t_yes_count;
          end
        end
        RESULT: begin
          if (bus.ack) begin
            state          <= IDLE;
            result_valid_r <= 1'b0;
            verdict_r      <= '0;
            timed_out_r    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.voted        = voted_r;
  assign bus.yes_count    = yes_count_r;
  assign bus.result_valid = result_valid_r;
  assign bus.verdict      = verdict_r;
  assign bus.timed_out    = timed_out_r;

endmodule
